// File: rtl/multicycle_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_unit_pkg
// Shared definitions for the multi-cycle RV32I control unit: state encoding,
// major opcodes, datapath select encodings and the packed control bundle
// produced by the per-state decoder.
// -----------------------------------------------------------------------------
package multicycle_ctrl_unit_pkg;

   // Control FSM states; HALT is absorbing.
   typedef enum logic [2:0] {
      S_IF1  = 3'd0,
      S_IF2  = 3'd1,
      S_ID   = 3'd2,
      S_EX1  = 3'd3,
      S_EX2  = 3'd4,
      S_MEM  = 3'd5,
      S_WB   = 3'd6,
      S_HALT = 3'd7
   } state_e;

   // RV32I major opcodes (instruction bits [6:0]).
   typedef enum logic [6:0] {
      ARITHMETIC     = 7'b0110011,
      ARITHMETIC_IMM = 7'b0010011,
      LOAD           = 7'b0000011,
      STORE          = 7'b0100011,
      BRANCH         = 7'b1100011,
      JAL            = 7'b1101111,
      JALR           = 7'b1100111,
      ECALL          = 7'b1110011
   } opcode_e;

   typedef enum logic [1:0] {
      PC_SRC_ALU    = 2'b00,
      PC_SRC_ALUOUT = 2'b01,
      PC_SRC_PC4    = 2'b10
   } pc_source_e;

   typedef enum logic [1:0] {
      SRC_B_RS2  = 2'b00,
      SRC_B_FOUR = 2'b01,
      SRC_B_IMM  = 2'b10
   } alu_src_b_e;

   typedef enum logic [1:0] {
      ALU_OP_ADD    = 2'b00,
      ALU_OP_BRANCH = 2'b01,
      ALU_OP_FUNCT  = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALUOUT = 2'b00,
      WB_MDR    = 2'b01,
      WB_PC4    = 2'b10
   } wb_sel_e;

   // Datapath controls decoded from (state, opcode).
   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_source;
      logic       pc4_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic [1:0] wb_sel;
   } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_unit_if
// Bundles the control unit's connections to the next-state logic and the
// datapath.
//   master : control unit side (consumes next_state_in/opcode/bcond/mem_ready,
//            drives current_state, datapath enables/selects, status, counters)
//   slave  : surrounding core side (mirror image of master)
// -----------------------------------------------------------------------------
interface multicycle_ctrl_unit_if #(
   parameter int STATE_W = 3,
   parameter int CNT_W   = 32
);
   logic [STATE_W-1:0] next_state_in;
   logic [6:0]         part_of_inst;
   logic               alu_bcond;
   logic               mem_ready;

   logic [STATE_W-1:0] current_state;
   logic               pc_write;
   logic [1:0]         pc_source;
   logic               pc4_write;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic               reg_write;
   logic [1:0]         wb_sel;
   logic               instr_retired;
   logic               mem_timeout;
   logic               is_halted;
   logic [CNT_W-1:0]   cycle_count;
   logic [CNT_W-1:0]   retire_count;

   modport master (
      input  next_state_in, part_of_inst, alu_bcond, mem_ready,
      output current_state, pc_write, pc_source, pc4_write, i_or_d,
             mem_read, mem_write, ir_write, alu_src_a, alu_src_b, alu_op,
             reg_write, wb_sel, instr_retired, mem_timeout, is_halted,
             cycle_count, retire_count
   );

   modport slave (
      output next_state_in, part_of_inst, alu_bcond, mem_ready,
      input  current_state, pc_write, pc_source, pc4_write, i_or_d,
             mem_read, mem_write, ir_write, alu_src_a, alu_src_b, alu_op,
             reg_write, wb_sel, instr_retired, mem_timeout, is_halted,
             cycle_count, retire_count
   );
endinterface

// File: rtl/ctrl_wait_timer.sv
// -----------------------------------------------------------------------------
// ctrl_wait_timer
// Counts consecutive memory-stall cycles and flags a timeout.
//   clk, reset : clock, async active-high reset
//   stall_i    : control FSM is waiting on mem_ready this cycle
//   clear_i    : FSM advances this cycle; restart the count
//   expire_o   : this stall cycle is the MAX_WAIT-th in a row (force HALT)
//   timeout_o  : sticky flag, set on expire, cleared only by reset
// -----------------------------------------------------------------------------
module ctrl_wait_timer #(
   parameter int MAX_WAIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic stall_i,
   input  logic clear_i,
   output logic expire_o,
   output logic timeout_o
);
   localparam int CW = $clog2(MAX_WAIT);

   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          timeout_q,  timeout_d;

   assign expire_o  = stall_i & (wait_cnt_q == CW'(MAX_WAIT - 1));
   assign timeout_o = timeout_q;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q | expire_o;
      if (clear_i) begin
         wait_cnt_d = '0;
      end else if (stall_i && !expire_o) begin
         wait_cnt_d = wait_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples values from before the edge.
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end
endmodule

// File: rtl/multicycle_ctrl_unit.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_unit
// State register and Moore-style control decoder for the multi-cycle RV32I
// core. Registers next_state_in from the next-state logic (holding it while a
// memory request is outstanding), decodes (state, opcode) into datapath
// controls, traps to HALT on a memory wait timeout and pulses instr_retired
// once per completed instruction.
//   clk   : core clock
//   reset : asynchronous, active-high reset
//   bus   : multicycle_ctrl_unit_if.master (inputs next_state_in, part_of_inst,
//           alu_bcond, mem_ready; outputs current_state, datapath controls,
//           instr_retired, mem_timeout, is_halted, cycle_count, retire_count)
// Optional feature: define MULTICYCLE_PERF_COUNTER_EN to build saturating
// cycle/retire counters; otherwise both counter outputs are tied to zero.
// -----------------------------------------------------------------------------
module multicycle_ctrl_unit
   import multicycle_ctrl_unit_pkg::*;
#(
   parameter int STATE_W  = 3,
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_ctrl_unit_if.master bus
);
   logic [STATE_W-1:0] state_q, state_d;
   logic in_if1, in_ex1, in_ex2, in_mem, in_wb, in_halt;
   logic is_load, is_store, is_branch, is_jal, is_jalr, is_r_or_i;
   logic stall, expire, timeout, retire;
   ctrl_t ctrl, ctrl_out;

   assign in_if1  = (state_q == STATE_W'(S_IF1));
   assign in_ex1  = (state_q == STATE_W'(S_EX1));
   assign in_ex2  = (state_q == STATE_W'(S_EX2));
   assign in_mem  = (state_q == STATE_W'(S_MEM));
   assign in_wb   = (state_q == STATE_W'(S_WB));
   assign in_halt = (state_q == STATE_W'(S_HALT));

   assign is_load    = (bus.part_of_inst == LOAD);
   assign is_store   = (bus.part_of_inst == STORE);
   assign is_branch  = (bus.part_of_inst == BRANCH);
   assign is_jal     = (bus.part_of_inst == JAL);
   assign is_jalr    = (bus.part_of_inst == JALR);
   assign is_r_or_i  = (bus.part_of_inst == ARITHMETIC) ||
                       (bus.part_of_inst == ARITHMETIC_IMM);

   // Only instruction fetch and data load/store wait on memory.
   assign stall = (in_if1 | (in_mem & (is_load | is_store))) & ~bus.mem_ready;

   ctrl_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk       (clk),
      .reset     (reset),
      .stall_i   (stall),
      .clear_i   (~stall),
      .expire_o  (expire),
      .timeout_o (timeout)
   );

   // ---------------- state register ----------------
   always_comb begin
      state_d = bus.next_state_in;
      if (in_halt || expire) begin
         state_d = STATE_W'(S_HALT);
      end else if (stall) begin
         state_d = state_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= STATE_W'(S_IF1);
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- per-state control decode ----------------
   always_comb begin
      ctrl = '0;
      case (state_q)
         STATE_W'(S_IF2): begin
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.alu_op    = ALU_OP_ADD;
            ctrl.pc4_write = 1'b1;
         end
         STATE_W'(S_ID): begin
            // Precompute the branch target into ALUOut.
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
         end
         STATE_W'(S_EX1): begin
            ctrl.alu_src_a = ~is_jal;
            ctrl.alu_src_b = (bus.part_of_inst == ARITHMETIC) ? SRC_B_RS2 : SRC_B_IMM;
            if (is_r_or_i) begin
               ctrl.alu_op = ALU_OP_FUNCT;
            end else if (is_branch) begin
               ctrl.alu_op = ALU_OP_BRANCH;
            end else begin
               ctrl.alu_op = ALU_OP_ADD;
            end
            if (is_jal || is_jalr) begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = PC_SRC_ALU;
            end else if (is_branch && !bus.alu_bcond) begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = PC_SRC_PC4;
            end
         end
         STATE_W'(S_EX2): begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_ALUOUT;
         end
         STATE_W'(S_MEM): begin
            ctrl.i_or_d    = 1'b1;
            ctrl.mem_read  = is_load;
            ctrl.mem_write = is_store;
            if (is_store && bus.mem_ready) begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = PC_SRC_PC4;
            end
         end
         STATE_W'(S_WB): begin
            ctrl.reg_write = 1'b1;
            if (is_load) begin
               ctrl.wb_sel = WB_MDR;
            end else if (is_jal || is_jalr) begin
               ctrl.wb_sel = WB_PC4;
            end else begin
               ctrl.wb_sel = WB_ALUOUT;
            end
            if (!(is_jal || is_jalr)) begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = PC_SRC_PC4;
            end
         end
         STATE_W'(S_HALT): begin
            ctrl = '0;
         end
         default: begin
            // IF1, and any illegal encoding, fetch from the PC.
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b0;
            ctrl.ir_write = bus.mem_ready;
         end
      endcase
   end

   // Enables are forced low for as long as reset is held, not just at the edge.
   assign ctrl_out = reset ? ctrl_t'('0) : ctrl;

   assign retire = ~reset & ~stall & (bus.next_state_in == STATE_W'(S_IF1)) &
                   (in_wb | in_ex2 | (in_ex1 & is_branch & ~bus.alu_bcond) |
                    (in_mem & is_store));

   assign bus.current_state = state_q;
   assign bus.pc_write      = ctrl_out.pc_write;
   assign bus.pc_source     = ctrl_out.pc_source;
   assign bus.pc4_write     = ctrl_out.pc4_write;
   assign bus.i_or_d        = ctrl_out.i_or_d;
   assign bus.mem_read      = ctrl_out.mem_read;
   assign bus.mem_write     = ctrl_out.mem_write;
   assign bus.ir_write      = ctrl_out.ir_write;
   assign bus.alu_src_a     = ctrl_out.alu_src_a;
   assign bus.alu_src_b     = ctrl_out.alu_src_b;
   assign bus.alu_op        = ctrl_out.alu_op;
   assign bus.reg_write     = ctrl_out.reg_write;
   assign bus.wb_sel        = ctrl_out.wb_sel;
   assign bus.instr_retired = retire;
   assign bus.mem_timeout   = timeout;
   assign bus.is_halted     = in_halt;

   // ---------------- optional performance counters ----------------
`ifdef MULTICYCLE_PERF_COUNTER_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (!in_halt && (cycle_cnt_q != {CNT_W{1'b1}})) begin
         cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
      if (retire && (retire_cnt_q != {CNT_W{1'b1}})) begin
         retire_cnt_d = retire_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign bus.cycle_count  = cycle_cnt_q;
   assign bus.retire_count = retire_cnt_q;
`else
   assign bus.cycle_count  = {CNT_W{1'b0}};
   assign bus.retire_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_unit
// Directed bench for multicycle_ctrl_unit (MAX_WAIT = 4). Walks ADD, LOAD
// with memory stalls, taken/not-taken BRANCH, JAL, STORE, reset during a
// store, a timeout cycle rescued by mem_ready, and a fetch timeout into HALT.
// Counter expectations follow MULTICYCLE_PERF_COUNTER_EN.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_unit;
   import multicycle_ctrl_unit_pkg::*;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_source;
      logic       pc4_write;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       instr_retired;
      logic       mem_timeout;
      logic       is_halted;
   } ctl_t;

   logic clk = 1'b0;
   logic reset;
   int   tests  = 0;
   int   failed = 0;
   ctl_t e;

`ifdef MULTICYCLE_PERF_COUNTER_EN
   localparam logic [31:0] EXP_CYC_3ADD = 32'd15;
   localparam logic [31:0] EXP_RET_3ADD = 32'd3;
   localparam logic [31:0] EXP_CYC_HALT = 32'd4;
`else
   localparam logic [31:0] EXP_CYC_3ADD = 32'd0;
   localparam logic [31:0] EXP_RET_3ADD = 32'd0;
   localparam logic [31:0] EXP_CYC_HALT = 32'd0;
`endif

   multicycle_ctrl_unit_if #(.STATE_W(3), .CNT_W(32)) bus_if ();

   multicycle_ctrl_unit #(
      .STATE_W  (3),
      .MAX_WAIT (4),
      .CNT_W    (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic ctl_t obs_ctl();
      ctl_t o;
      o.pc_write      = bus_if.pc_write;
      o.pc_source     = bus_if.pc_source;
      o.pc4_write     = bus_if.pc4_write;
      o.i_or_d        = bus_if.i_or_d;
      o.mem_read      = bus_if.mem_read;
      o.mem_write     = bus_if.mem_write;
      o.ir_write      = bus_if.ir_write;
      o.alu_src_a     = bus_if.alu_src_a;
      o.alu_src_b     = bus_if.alu_src_b;
      o.alu_op        = bus_if.alu_op;
      o.reg_write     = bus_if.reg_write;
      o.wb_sel        = bus_if.wb_sel;
      o.instr_retired = bus_if.instr_retired;
      o.mem_timeout   = bus_if.mem_timeout;
      o.is_halted     = bus_if.is_halted;
      return o;
   endfunction

   task automatic expect_ctl(input string tag, input state_e st, input ctl_t exp_ctl);
      check({tag, " state"}, 32'(bus_if.current_state), 32'(st));
      check({tag, " ctl"}, 32'(obs_ctl()), 32'(exp_ctl));
   endtask

   task automatic drive(input state_e nxt, input opcode_e op, input logic ready, input logic bcond);
      bus_if.next_state_in = nxt;
      bus_if.part_of_inst  = op;
      bus_if.mem_ready     = ready;
      bus_if.alu_bcond     = bcond;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset ----------------
      reset = 1'b1;
      drive(S_IF2, ARITHMETIC, 1'b1, 1'b0);
      e = '0;
      expect_ctl("reset", S_IF1, e);
      check("reset cycle_count", bus_if.cycle_count, 32'd0);
      check("reset retire_count", bus_if.retire_count, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(S_IF2, ARITHMETIC, 1'b1, 1'b0);

      // ---------------- ADD #1, fully checked ----------------
      e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
      expect_ctl("add IF1", S_IF1, e);
      tick(); drive(S_ID, ARITHMETIC, 1'b1, 1'b0);
      e = '0; e.pc4_write = 1'b1; e.alu_src_b = 2'b01;
      expect_ctl("add IF2", S_IF2, e);
      tick(); drive(S_EX1, ARITHMETIC, 1'b1, 1'b0);
      e = '0; e.alu_src_b = 2'b10;
      expect_ctl("add ID", S_ID, e);
      tick(); drive(S_WB, ARITHMETIC, 1'b1, 1'b0);
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b00; e.alu_op = 2'b10;
      expect_ctl("add EX1", S_EX1, e);
      tick(); drive(S_IF1, ARITHMETIC, 1'b1, 1'b0);
      e = '0; e.reg_write = 1'b1; e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_retired = 1'b1;
      expect_ctl("add WB", S_WB, e);
      tick(); drive(S_IF2, ARITHMETIC, 1'b1, 1'b0);
      e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
      expect_ctl("add back IF1", S_IF1, e);

      // ---------------- ADD #2, #3 ----------------
      for (int k = 0; k < 2; k++) begin
         tick(); drive(S_ID, ARITHMETIC, 1'b1, 1'b0);
         tick(); drive(S_EX1, ARITHMETIC, 1'b1, 1'b0);
         tick(); drive(S_WB, ARITHMETIC, 1'b1, 1'b0);
         tick(); drive(S_IF1, ARITHMETIC, 1'b1, 1'b0);
         check("addN WB state", 32'(bus_if.current_state), 32'(S_WB));
         check("addN retired", 32'(bus_if.instr_retired), 32'd1);
         tick(); drive(S_IF2, ARITHMETIC, 1'b1, 1'b0);
      end
      check("3add cycle_count", bus_if.cycle_count, EXP_CYC_3ADD);
      check("3add retire_count", bus_if.retire_count, EXP_RET_3ADD);

      // ---------------- LOAD with 3 stall cycles in MEM ----------------
      drive(S_IF2, LOAD, 1'b1, 1'b0);
      tick(); drive(S_ID, LOAD, 1'b1, 1'b0);
      tick(); drive(S_EX1, LOAD, 1'b1, 1'b0);
      tick(); drive(S_MEM, LOAD, 1'b1, 1'b0);
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b00;
      expect_ctl("load EX1", S_EX1, e);
      tick(); drive(S_WB, LOAD, 1'b0, 1'b0);
      e = '0; e.i_or_d = 1'b1; e.mem_read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_ctl("load MEM wait", S_MEM, e);
         tick(); drive(S_WB, LOAD, (k == 2), 1'b0);
      end
      expect_ctl("load MEM done", S_MEM, e);
      tick(); drive(S_IF1, LOAD, 1'b1, 1'b0);
      e = '0; e.reg_write = 1'b1; e.wb_sel = 2'b01; e.pc_write = 1'b1; e.pc_source = 2'b10;
      e.instr_retired = 1'b1;
      expect_ctl("load WB", S_WB, e);

      // ---------------- BRANCH taken ----------------
      tick(); drive(S_IF2, BRANCH, 1'b1, 1'b1);
      tick(); drive(S_ID, BRANCH, 1'b1, 1'b1);
      tick(); drive(S_EX1, BRANCH, 1'b1, 1'b1);
      tick(); drive(S_EX2, BRANCH, 1'b1, 1'b1);
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b01;
      expect_ctl("beq taken EX1", S_EX1, e);
      tick(); drive(S_IF1, BRANCH, 1'b1, 1'b1);
      e = '0; e.pc_write = 1'b1; e.pc_source = 2'b01; e.instr_retired = 1'b1;
      expect_ctl("beq taken EX2", S_EX2, e);

      // ---------------- BRANCH not taken ----------------
      tick(); drive(S_IF2, BRANCH, 1'b1, 1'b0);
      tick(); drive(S_ID, BRANCH, 1'b1, 1'b0);
      tick(); drive(S_EX1, BRANCH, 1'b1, 1'b0);
      tick(); drive(S_IF1, BRANCH, 1'b1, 1'b0);
      e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b01;
      e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_retired = 1'b1;
      expect_ctl("beq not taken EX1", S_EX1, e);
      tick(); drive(S_IF2, JAL, 1'b1, 1'b0);
      check("beq not taken skips EX2", 32'(bus_if.current_state), 32'(S_IF1));

      // ---------------- JAL ----------------
      tick(); drive(S_ID, JAL, 1'b1, 1'b0);
      tick(); drive(S_EX1, JAL, 1'b1, 1'b0);
      tick(); drive(S_WB, JAL, 1'b1, 1'b0);
      e = '0; e.alu_src_a = 1'b0; e.alu_src_b = 2'b10; e.alu_op = 2'b00;
      e.pc_write = 1'b1; e.pc_source = 2'b00;
      expect_ctl("jal EX1", S_EX1, e);
      tick(); drive(S_IF1, JAL, 1'b1, 1'b0);
      e = '0; e.reg_write = 1'b1; e.wb_sel = 2'b10; e.instr_retired = 1'b1;
      expect_ctl("jal WB", S_WB, e);

      // ---------------- STORE completing ----------------
      tick(); drive(S_IF2, STORE, 1'b1, 1'b0);
      tick(); drive(S_ID, STORE, 1'b1, 1'b0);
      tick(); drive(S_EX1, STORE, 1'b1, 1'b0);
      tick(); drive(S_MEM, STORE, 1'b1, 1'b0);
      tick(); drive(S_IF1, STORE, 1'b1, 1'b0);
      e = '0; e.i_or_d = 1'b1; e.mem_write = 1'b1; e.pc_write = 1'b1; e.pc_source = 2'b10;
      e.instr_retired = 1'b1;
      expect_ctl("sw MEM ready", S_MEM, e);

      // ---------------- reset in the middle of a STORE ----------------
      tick(); drive(S_IF2, STORE, 1'b1, 1'b0);
      tick(); drive(S_ID, STORE, 1'b1, 1'b0);
      tick(); drive(S_EX1, STORE, 1'b1, 1'b0);
      tick(); drive(S_MEM, STORE, 1'b1, 1'b0);
      tick(); drive(S_IF1, STORE, 1'b0, 1'b0);
      e = '0; e.i_or_d = 1'b1; e.mem_write = 1'b1;
      expect_ctl("sw MEM wait", S_MEM, e);
      #2;
      reset = 1'b1;
      #1;
      e = '0;
      expect_ctl("reset mid store", S_IF1, e);
      check("reset mid store cycle_count", bus_if.cycle_count, 32'd0);
      tick();
      reset = 1'b0;
      drive(S_IF2, ARITHMETIC, 1'b0, 1'b0);

      // ---------------- mem_ready in the timeout cycle wins ----------------
      e = '0; e.mem_read = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_ctl("fetch wait", S_IF1, e);
         tick(); drive(S_IF2, ARITHMETIC, (k == 2), 1'b0);
      end
      e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1;
      expect_ctl("fetch rescued", S_IF1, e);
      tick(); drive(S_IF1, ARITHMETIC, 1'b1, 1'b0);
      e = '0; e.pc4_write = 1'b1; e.alu_src_b = 2'b01;
      expect_ctl("no trap after rescue", S_IF2, e);
      tick();

      // ---------------- fetch timeout into HALT ----------------
      reset = 1'b1;
      drive(S_IF2, ARITHMETIC, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      drive(S_IF2, ARITHMETIC, 1'b0, 1'b0);
      e = '0; e.mem_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expect_ctl("fetch stall", S_IF1, e);
         tick(); drive(S_IF2, ARITHMETIC, 1'b0, 1'b0);
      end
      e = '0; e.mem_timeout = 1'b1; e.is_halted = 1'b1;
      expect_ctl("timeout HALT", S_HALT, e);
      check("halt entry cycle_count", bus_if.cycle_count, EXP_CYC_HALT);
      for (int k = 0; k < 3; k++) begin
         tick(); drive(S_IF2, ARITHMETIC, 1'b1, 1'b0);
         expect_ctl("HALT absorbing", S_HALT, e);
      end
      check("halt frozen cycle_count", bus_if.cycle_count, EXP_CYC_HALT);
      check("halt retire_count", bus_if.retire_count, 32'd0);

      // ---------------- reset clears the sticky timeout ----------------
      reset = 1'b1;
      #1;
      e = '0;
      expect_ctl("reset from HALT", S_IF1, e);
      tick();
      reset = 1'b0;
      #1;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
- State register and Moore-style control-signal generator for the multi-cycle RV32I core.
- Sits directly downstream of the next-state logic block: it registers that block's `next_state` and drives `current_state` back to it.
- Decodes (`current_state`, opcode) into datapath controls.
- Adds a memory ready-handshake stall, a wait-timeout trap and a retire pulse.

Parameters:
- STATE_W, 3, width of state encoding.
- MAX_WAIT, 16, maximum consecutive stall cycles before timeout trap (>=2).
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- next_state_in  in  STATE_W  state proposed by the next-state logic.
- part_of_inst  in  7  opcode field of the IR.
- alu_bcond  in  1  branch condition from the ALU.
- mem_ready  in  1  memory completion for the current request.
- current_state  out  STATE_W  registered state, fed back to the next-state logic.
- pc_write  out  1  PC update enable.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = PC+4 register.
- pc4_write  out  1  latch PC+4 register.
- i_or_d  out  1  0 = PC address, 1 = ALUOut address.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR latch enable.
- alu_src_a  out  1  0 = PC, 1 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = add, 01 = branch compare, 10 = funct-decoded.
- reg_write  out  1  register-file write.
- wb_sel  out  2  00 = ALUOut, 01 = MDR, 10 = PC+4.
- instr_retired  out  1  one-cycle pulse per completed instruction.
- mem_timeout  out  1  sticky timeout flag.
- is_halted  out  1  high in HALT.
- cycle_count  out  CNT_W  optional counter.
- retire_count  out  CNT_W  optional counter.

Behaviour:
- **Reset** (async, reset=1):
  - current_state = IF1.
  - wait counter = 0; mem_timeout = 0.
  - Counters = 0.
  - All enable outputs 0 while reset is asserted.
- **Stall condition:** stall = (state==IF1) or (state==MEM and opcode is LOAD or STORE), and mem_ready==0.
- **State update** on posedge clk:
  - Stall: hold state; wait counter +1.
  - Otherwise: current_state <= next_state_in; wait counter cleared.
- **Timeout:** if stall persists with wait counter == MAX_WAIT-1:
  - Next state is forced to HALT.
  - mem_timeout set to 1 and stays 1 until reset.
- **HALT:** absorbing regardless of next_state_in. is_halted=1; every write/request output is 0.
- **Per-state outputs** (unlisted outputs are 0):
  - IF1:
    - mem_read=1, i_or_d=0.
    - ir_write=mem_ready, i.e. only in the cycle the request completes.
  - IF2: alu_src_a=0, alu_src_b=01, alu_op=00, pc4_write=1.
  - ID: alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - EX1:
    - alu_src_a=1, except JAL uses 0.
    - alu_src_b=00 for R-type, 10 otherwise.
    - alu_op=10 for R/I-type, 01 for BRANCH, 00 otherwise.
    - JAL/JALR: pc_write=1, pc_source=00.
    - BRANCH with alu_bcond=0: pc_write=1, pc_source=10.
  - EX2: pc_write=1, pc_source=01.
  - MEM:
    - i_or_d=1; mem_read=LOAD; mem_write=STORE.
    - STORE with mem_ready=1: pc_write=1, pc_source=10.
  - WB:
    - reg_write=1.
    - wb_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
    - Non-jump: pc_write=1, pc_source=10.
- **instr_retired=1** in the non-stalled cycle that leaves WB, EX2, not-taken EX1, or MEM-store with next_state_in==IF1.
- **Simultaneous events:** mem_ready arriving in the timeout cycle wins; there is no trap and the state advances normally.
- **Illegal state encoding:** treated as IF1 for outputs; next clock loads next_state_in.

Optional Feature:
- Macro: MULTICYCLE_PERF_COUNTER_EN.
- When defined:
  - cycle_count increments every non-HALT cycle.
  - retire_count increments on each instr_retired.
  - Both saturate at all-ones and are cleared by reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- **Shared package/header:**
  - State encoding: IF1=0, IF2=1, ID=2, EX1=3, EX2=4, MEM=5, WB=6, HALT=7.
  - Opcode constants: ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL.
  - Encodings for pc_source, alu_src_b, alu_op and wb_sel.
- **Sub-module:** ctrl_wait_timer holds the wait counter and timeout flag. Its inputs are stall and clear; its outputs are expire and sticky flag.

Test Plan:
- ADD (opcode 0110011), mem_ready tied 1 → states IF1,IF2,ID,EX1,WB; reg_write=1 only in WB; one instr_retired pulse.
- LOAD with mem_ready low 3 cycles in MEM → MEM held 4 cycles; mem_read=1 throughout; then WB with wb_sel=01.
- BRANCH, alu_bcond=1 → EX1 then EX2 with pc_source=01, pc_write=1; with bcond=0 → pc_source=10 in EX1, no EX2.
- mem_ready held 0 in IF1, MAX_WAIT=4 → HALT after 4 cycles; mem_timeout=1 and is_halted=1 persist until reset.
- reset asserted mid-MEM-store → outputs 0 immediately, state IF1 asynchronously, mem_write dropped.
- With MULTICYCLE_PERF_COUNTER_EN: 3 ADDs, no stalls → retire_count=3, cycle_count=15; counters freeze in HALT.
